// File: rtl/hit_judge.sv
// hit_judge: timing judge for the rhythm-game note lane.
// Debounces the player button, grades each accepted press against the two
// bottom slots of the scrolling note matrix (rows 0-1 = perfect, rows 2-3 =
// near), flags notes that scroll out unjudged, and keeps saturating tallies.
// All outputs are registered; there is no combinational input-to-output path.

module hit_judge #(
    parameter int LANE_LO    = 12,
    parameter int LANE_HI    = 15,
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 10,
    parameter int PTS_SCORE  = 3,
    parameter int PTS_NEAR   = 1
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  KEY,
    input  logic [15:0][15:0]     RedPixels,
    input  logic                  step,
    output logic                  score,
    output logic                  near,
    output logic                  miss,
    output logic [1:0]            clr_slot,
    output logic [CNT_W+1:0]      points,
    output logic [CNT_W-1:0]      combo,
    output logic [CNT_W-1:0]      max_combo
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam int PW = CNT_W + 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W+1:0] PTS_MAX = '1;

    typedef enum logic [1:0] {
        UP        = 2'd0,
        DOWN_WAIT = 2'd1,
        DOWN      = 2'd2,
        UP_WAIT   = 2'd3
    } deb_state_t;

    deb_state_t       deb_state;
    logic [DEB_W-1:0] deb_cnt;
    logic             press;

    logic             occ0;
    logic             occ1;
    logic             jd0;
    logic             jd1;
    logic             grade0;
    logic             grade1;
    logic             miss_now;

    logic [PW-1:0]    pts_sum;
    logic [CNT_W+1:0] points_next;
    logic [CNT_W-1:0] combo_next;
    logic [CNT_W-1:0] max_next;

    // Only rows 0-3 of the lane columns matter; the rest of the matrix is
    // folded here so the full port stays connected without lint noise.
    logic             unused_pixels;
    assign unused_pixels = ^RedPixels;

    // Slot occupancy: any lit lane pixel in rows 0-1 (slot 0) or rows 2-3 (slot 1)
    always_comb begin
        occ0 = 1'b0;
        occ1 = 1'b0;
        for (int c = LANE_LO; c <= LANE_HI; c++) begin
            occ0 = occ0 | RedPixels[0][c] | RedPixels[1][c];
            occ1 = occ1 | RedPixels[2][c] | RedPixels[3][c];
        end
    end

    // Debounce FSM: a level is accepted only after it has held through the wait
    // state; entering DOWN emits a single registered press pulse
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            deb_state <= UP;
            deb_cnt   <= '0;
            press     <= 1'b0;
        end else begin
            press <= 1'b0;
            case (deb_state)
                UP: begin
                    if (KEY) begin
                        deb_state <= DOWN_WAIT;
                        deb_cnt   <= '0;
                    end
                end
                DOWN_WAIT: begin
                    if (!KEY) begin
                        deb_state <= UP;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_state <= DOWN;
                        press     <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                DOWN: begin
                    if (!KEY) begin
                        deb_state <= UP_WAIT;
                        deb_cnt   <= '0;
                    end
                end
                UP_WAIT: begin
                    if (KEY) begin
                        deb_state <= DOWN;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_state <= UP;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                default: begin
                    deb_state <= UP;
                    deb_cnt   <= '0;
                end
            endcase
        end
    end

    // Grading against the pre-step slots: slot 0 has priority, judged slots
    // count as empty, and an unjudged slot 0 leaving on step is a miss
    always_comb begin
        grade0   = press & occ0 & ~jd0;
        grade1   = press & ~grade0 & occ1 & ~jd1;
        miss_now = step & occ0 & ~jd0 & ~grade0;
    end

    // Next tally values; a near that coincides with a miss is graded first and
    // then wiped by the miss, so the combo ends at zero in that cycle
    always_comb begin
        pts_sum = {1'b0, points};
        if (grade0) begin
            pts_sum = pts_sum + PW'(PTS_SCORE);
        end else if (grade1) begin
            pts_sum = pts_sum + PW'(PTS_NEAR);
        end
        if (pts_sum > {1'b0, PTS_MAX}) begin
            points_next = PTS_MAX;
        end else begin
            points_next = pts_sum[PW-2:0];
        end

        combo_next = combo;
        if (grade0 | grade1) begin
            if (combo != CNT_MAX) begin
                combo_next = combo + CNT_W'(1);
            end
        end
        if (miss_now) begin
            combo_next = '0;
        end

        max_next = (combo_next > max_combo) ? combo_next : max_combo;
    end

    // Register the result pulses and move judged flags along with the scroll
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            score    <= 1'b0;
            near     <= 1'b0;
            miss     <= 1'b0;
            clr_slot <= 2'b00;
            jd0      <= 1'b0;
            jd1      <= 1'b0;
        end else begin
            score    <= grade0;
            near     <= grade1;
            miss     <= miss_now;
            clr_slot <= {grade1, grade0};
            if (step) begin
                jd0 <= jd1 | grade1;
                jd1 <= 1'b0;
            end else begin
                if (grade0) begin
                    jd0 <= 1'b1;
                end
                if (grade1) begin
                    jd1 <= 1'b1;
                end
            end
        end
    end

    // Saturating tallies for points, current combo and best combo
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            points    <= '0;
            combo     <= '0;
            max_combo <= '0;
        end else begin
            points    <= points_next;
            combo     <= combo_next;
            max_combo <= max_next;
        end
    end

endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: self-checking bench for hit_judge.
// Two instances share the stimulus: one with the default tally width and one
// with CNT_W=3 so saturation is reachable. Expected values come from a
// note-level model: the full matrix is scrolled here, judged marks travel with
// their row pair, and the button is modelled as a run-length debouncer.

module tb_hit_judge;

    localparam int LANE_LO    = 12;
    localparam int LANE_HI    = 15;
    localparam int DEB_CYCLES = 4;
    localparam int CW_A       = 10;
    localparam int CW_B       = 3;

    logic clk = 1'b0;
    logic RST = 1'b1;
    logic KEY = 1'b0;
    logic step = 1'b0;
    logic [15:0][15:0] red = '0;

    logic score_a, near_a, miss_a;
    logic [1:0] clr_a;
    logic [CW_A+1:0] points_a;
    logic [CW_A-1:0] combo_a, max_a;

    logic score_b, near_b, miss_b;
    logic [1:0] clr_b;
    logic [CW_B+1:0] points_b;
    logic [CW_B-1:0] combo_b, max_b;

    int n_checks = 0;
    int n_fails  = 0;
    int cnt_score = 0, cnt_near = 0, cnt_miss = 0;

    bit fill_en = 1'b0;
    bit pend_shift = 1'b0;

    // reference model state
    bit judged [8];
    bit lvl;
    int run;
    bit press_q;
    int m_points [2];
    int m_combo  [2];
    int m_max    [2];
    bit e_score, e_near, e_miss;
    logic [1:0] e_clr;

    int key_left, step_left;
    bit kv, sv;

    always #5 clk = ~clk;

    hit_judge #(.LANE_LO(LANE_LO), .LANE_HI(LANE_HI), .DEB_CYCLES(DEB_CYCLES),
                .CNT_W(CW_A), .PTS_SCORE(3), .PTS_NEAR(1)) dut_a (
        .clk(clk), .RST(RST), .KEY(KEY), .RedPixels(red), .step(step),
        .score(score_a), .near(near_a), .miss(miss_a), .clr_slot(clr_a),
        .points(points_a), .combo(combo_a), .max_combo(max_a));

    hit_judge #(.LANE_LO(LANE_LO), .LANE_HI(LANE_HI), .DEB_CYCLES(DEB_CYCLES),
                .CNT_W(CW_B), .PTS_SCORE(3), .PTS_NEAR(1)) dut_b (
        .clk(clk), .RST(RST), .KEY(KEY), .RedPixels(red), .step(step),
        .score(score_b), .near(near_b), .miss(miss_b), .clr_slot(clr_b),
        .points(points_b), .combo(combo_b), .max_combo(max_b));

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit lane_occupied(input int pair);
        bit hit = 1'b0;
        for (int r = 2 * pair; r <= 2 * pair + 1; r++)
            for (int c = LANE_LO; c <= LANE_HI; c++)
                if (red[r][c]) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [15:0] new_row();
        logic [15:0] row;
        row = 16'($urandom);
        for (int c = LANE_LO; c <= LANE_HI; c++) row[c] = 1'b0;
        if (fill_en && $urandom_range(0, 2) == 0)
            row[LANE_LO + $urandom_range(0, LANE_HI - LANE_LO)] = 1'b1;
        return row;
    endfunction

    task automatic apply_shift();
        if (pend_shift) begin
            for (int r = 0; r < 14; r++) red[r] = red[r + 2];
            red[14] = new_row();
            red[15] = new_row();
            pend_shift = 1'b0;
        end
    endtask

    task automatic place_note(input int r, input int c);
        apply_shift();
        red[r][c] = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) judged[i] = 1'b0;
        lvl = 1'b0; run = 0; press_q = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_points[i] = 0; m_combo[i] = 0; m_max[i] = 0;
        end
        e_score = 1'b0; e_near = 1'b0; e_miss = 1'b0; e_clr = 2'b00;
    endtask

    // One clock of the reference model, using the inputs sampled at this edge
    task automatic model_cycle(input bit k, input bit s);
        bit p, live0, live1, g0, g1, mx;
        int w, maxc, maxp;
        p = press_q;
        press_q = 1'b0;
        if (k != lvl) begin
            run++;
            if (run == DEB_CYCLES + 1) begin
                lvl = k; run = 0; press_q = k;
            end
        end else begin
            run = 0;
        end
        live0 = lane_occupied(0) && !judged[0];
        live1 = lane_occupied(1) && !judged[1];
        g0 = p && live0;
        g1 = p && !g0 && live1;
        mx = s && live0 && !g0;
        for (int i = 0; i < 2; i++) begin
            w = (i == 0) ? CW_A : CW_B;
            maxc = (1 << w) - 1;
            maxp = (1 << (w + 2)) - 1;
            if (g0) m_points[i] = (m_points[i] + 3 > maxp) ? maxp : m_points[i] + 3;
            else if (g1) m_points[i] = (m_points[i] + 1 > maxp) ? maxp : m_points[i] + 1;
            if (g0 || g1) m_combo[i] = (m_combo[i] < maxc) ? m_combo[i] + 1 : maxc;
            if (mx) m_combo[i] = 0;
            if (m_combo[i] > m_max[i]) m_max[i] = m_combo[i];
        end
        if (g0) judged[0] = 1'b1;
        if (g1) judged[1] = 1'b1;
        if (s) begin
            for (int i = 0; i < 7; i++) judged[i] = judged[i + 1];
            judged[7] = 1'b0;
            pend_shift = 1'b1;
        end
        e_score = g0; e_near = g1; e_miss = mx; e_clr = {g1, g0};
    endtask

    task automatic applyStimulus(input bit k, input bit s);
        @(negedge clk);
        apply_shift();
        KEY = k;
        step = s;
        model_cycle(k, s);
        @(posedge clk);
        #1;
        checkOutput("score_a", score_a, e_score);
        checkOutput("near_a", near_a, e_near);
        checkOutput("miss_a", miss_a, e_miss);
        checkOutput("clr_a", clr_a, e_clr);
        checkOutput("points_a", points_a, m_points[0]);
        checkOutput("combo_a", combo_a, m_combo[0]);
        checkOutput("max_a", max_a, m_max[0]);
        checkOutput("score_b", score_b, e_score);
        checkOutput("miss_b", miss_b, e_miss);
        checkOutput("points_b", points_b, m_points[1]);
        checkOutput("combo_b", combo_b, m_combo[1]);
        checkOutput("max_b", max_b, m_max[1]);
        cnt_score += int'(score_a);
        cnt_near  += int'(near_a);
        cnt_miss  += int'(miss_a);
    endtask

    task automatic doReset();
        #2;
        RST = 1'b0;
        KEY = 1'b0;
        step = 1'b0;
        #1;
        checkOutput("rst_score", score_a, 0);
        checkOutput("rst_near", near_a, 0);
        checkOutput("rst_miss", miss_a, 0);
        checkOutput("rst_clr", clr_a, 0);
        checkOutput("rst_points_a", points_a, 0);
        checkOutput("rst_combo_a", combo_a, 0);
        checkOutput("rst_max_a", max_a, 0);
        checkOutput("rst_points_b", points_b, 0);
        checkOutput("rst_combo_b", combo_b, 0);
        checkOutput("rst_max_b", max_b, 0);
        model_reset();
        red = '0;
        pend_shift = 1'b0;
        cnt_score = 0; cnt_near = 0; cnt_miss = 0;
        @(negedge clk);
        RST = 1'b1;
        model_cycle(1'b0, 1'b0);
    endtask

    // Full press, release and a closing scroll step
    task automatic doHit();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
    endtask

    initial begin
        // perfect hit, then a long hold must not re-trigger
        doReset();
        place_note(0, 13);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("perfect_pulses", cnt_score, 1);
        checkOutput("perfect_clr", clr_a, 2'b01);
        checkOutput("perfect_points", points_a, 3);
        checkOutput("perfect_combo", combo_a, 1);
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("held_pulses", cnt_score, 1);

        // near hit, then a ghost press on an empty lane
        doReset();
        place_note(2, 14);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("near_pulses", cnt_near, 1);
        checkOutput("near_clr", clr_a, 2'b10);
        checkOutput("near_points", points_a, 1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0);
        red[2][14] = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("ghost_pulses", cnt_score + cnt_near, 1);
        checkOutput("ghost_combo", combo_a, 1);

        // reset in the middle of a debounce with points = 7
        doReset();
        place_note(0, 13); doHit();
        place_note(0, 13); doHit();
        place_note(2, 12); doHit();
        checkOutput("pre_reset_points", points_a, 7);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
        doReset();
        place_note(0, 14);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("post_reset_early", cnt_score, 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("post_reset_press", cnt_score, 1);

        // miss on an unjudged slot 0, no miss once it was judged
        doReset();
        place_note(0, 13); doHit();
        place_note(1, 12);
        applyStimulus(1'b0, 1'b1);
        checkOutput("miss_pulses", cnt_miss, 1);
        checkOutput("miss_combo", combo_a, 0);
        checkOutput("miss_max", max_a, 1);
        place_note(0, 15);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("judged_no_miss", cnt_miss, 1);

        // press and step in the same cycle
        doReset();
        place_note(0, 13);
        place_note(3, 12);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("same_cycle_score", cnt_score, 1);
        checkOutput("same_cycle_miss", cnt_miss, 0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("slot1_dropped_miss", cnt_miss, 1);

        // bouncing key never produces a press
        doReset();
        place_note(0, 12);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0);
            applyStimulus(1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0);
        end
        checkOutput("bounce_pulses", cnt_score + cnt_near, 0);

        // nine hits: narrow tallies saturate at 7
        doReset();
        for (int i = 0; i < 9; i++) begin
            place_note(0, 12);
            doHit();
        end
        checkOutput("sat_combo_b", combo_b, 7);
        checkOutput("sat_max_b", max_b, 7);
        checkOutput("sat_points_b", points_b, 27);
        checkOutput("sat_combo_a", combo_a, 9);

        // randomized play against the model
        doReset();
        fill_en = 1'b1;
        kv = 1'b0;
        key_left = 0;
        step_left = 3;
        for (int i = 0; i < 3000; i++) begin
            if (key_left == 0) begin
                kv = !kv;
                key_left = $urandom_range(1, 12);
            end
            key_left--;
            sv = (step_left == 0);
            if (sv) step_left = $urandom_range(2, 9);
            else step_left--;
            applyStimulus(kv, sv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
